down_count_monitor: RTL and testbench

Clock-domain capture stage that sits directly downstream of the 4-bit asynchronous (ripple) down counter. It synchronizes the counter's unstable ripple output into `clk`, accepts a value only once it has settled, and detects the 0 → max underflow. It maintains an extended wrap count and raises a sticky, acknowledged interrupt on each underflow, giving the rest of the design a clean, glitch-free view of the count.

---
 rtl/dcm_pkg.sv | 13 +
 rtl/dcm_sync_filter.sv | 45 ++++
 rtl/down_count_monitor.sv | 124 ++++++++++++
 tb/tb_down_count_monitor.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcm_pkg.sv
// Shared types and default sizing for the ripple down-counter capture stage.
package dcm_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } dcm_state_t;

  localparam int DCM_CNT_W    = 4;
  localparam int DCM_EXT_W    = 8;
  localparam int DCM_STABLE_N = 2;

endpackage

// File: rtl/dcm_sync_filter.sv
// Two-flop synchronizer for the ripple counter value plus a stability filter
// that flags when the synchronized value has held for STABLE_N samples.
module dcm_sync_filter
  import dcm_pkg::*;
#(
  parameter int CNT_W    = DCM_CNT_W,
  parameter int STABLE_N = DCM_STABLE_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt_in,
  output logic [CNT_W-1:0] s2,
  output logic             settled
);

  localparam int STAB_W = (STABLE_N > 2) ? $clog2(STABLE_N) : 1;
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_N - 1);

  logic [CNT_W-1:0]  s1;
  logic [1:0]        fill;
  logic [STAB_W-1:0] stab;

  // fill[1] marks that s1 and s2 both hold real samples rather than reset
  // zeros, so the reset value is never mistaken for a settled count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1   <= '0;
      s2   <= '0;
      fill <= '0;
      stab <= '0;
    end else begin
      s1   <= cnt_in;
      s2   <= s1;
      fill <= {fill[0], 1'b1};
      if (!fill[1] || (s1 != s2)) begin
        stab <= '0;
      end else if (stab != STAB_MAX) begin
        stab <= stab + STAB_W'(1);
      end
    end
  end

  assign settled = (stab == STAB_MAX);

endmodule

// File: rtl/down_count_monitor.sv
// Captures a settled view of the ripple down counter, counts 0 -> max underflows
// and raises a sticky interrupt. Define DCM_STEP_CHK_EN to add the step checker.
//
//   state | meaning
//   IDLE  | no value accepted yet (after reset or clr)
//   TRACK | cnt_q valid, following settled values and watching for underflow
module down_count_monitor
  import dcm_pkg::*;
#(
  parameter int CNT_W    = DCM_CNT_W,
  parameter int EXT_W    = DCM_EXT_W,
  parameter int STABLE_N = DCM_STABLE_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             clr,
  input  logic             irq_ack,
  output logic             cnt_vld,
  output logic [CNT_W-1:0] cnt_q,
  output logic             wrap_pulse,
  output logic [EXT_W-1:0] ext_cnt,
  output logic             irq
`ifdef DCM_STEP_CHK_EN
  ,
  output logic             err
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  dcm_state_t       state;
  dcm_state_t       state_nxt;
  logic [CNT_W-1:0] s2;
  logic             settled;
  logic             load;
  logic             wrap;

  dcm_sync_filter #(
    .CNT_W    (CNT_W),
    .STABLE_N (STABLE_N)
  ) u_sync_filter (
    .clk     (clk),
    .rst     (rst),
    .cnt_in  (cnt_in),
    .s2      (s2),
    .settled (settled)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    wrap      = 1'b0;
    case (state)
      IDLE: begin
        if (settled) begin
          load      = 1'b1;
          state_nxt = TRACK;
        end
      end
      TRACK: begin
        if (settled && (s2 != cnt_q)) begin
          load = 1'b1;
          wrap = (cnt_q == '0) && (s2 == CNT_MAX);
        end
      end
      default: state_nxt = IDLE;
    endcase
    // clr overrides any acceptance in the same cycle; cnt_q simply holds
    if (clr) begin
      state_nxt = IDLE;
      load      = 1'b0;
      wrap      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt_q      <= '0;
      wrap_pulse <= 1'b0;
      ext_cnt    <= '0;
      irq        <= 1'b0;
    end else begin
      state      <= state_nxt;
      wrap_pulse <= wrap;
      if (load) begin
        cnt_q <= s2;
      end
      if (clr) begin
        ext_cnt <= '0;
      end else if (wrap) begin
        ext_cnt <= ext_cnt + EXT_W'(1);
      end
      // a new underflow wins over a coincident acknowledge
      if (clr) begin
        irq <= 1'b0;
      end else if (wrap) begin
        irq <= 1'b1;
      end else if (irq_ack) begin
        irq <= 1'b0;
      end
    end
  end

  assign cnt_vld = (state == TRACK);

`ifdef DCM_STEP_CHK_EN
  logic step_bad;

  assign step_bad = load && (state == TRACK) && !wrap && (s2 != (cnt_q - CNT_W'(1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (clr) begin
      err <= 1'b0;
    end else if (step_bad) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_down_count_monitor.sv
// Self-checking bench for down_count_monitor: directed scenarios plus a random
// walk, all compared against a sample-history reference model.
module tb_down_count_monitor;

  localparam int CNT_W    = 4;
  localparam int EXT_W    = 8;
  localparam int STABLE_N = 2;
  localparam logic [CNT_W-1:0] MAXV = '1;

  logic             clk;
  logic             rst;
  logic [CNT_W-1:0] cnt_in;
  logic             clr;
  logic             irq_ack;
  logic             cnt_vld;
  logic [CNT_W-1:0] cnt_q;
  logic             wrap_pulse;
  logic [EXT_W-1:0] ext_cnt;
  logic             irq;
`ifdef DCM_STEP_CHK_EN
  logic             err;
`endif

  int tests_run;
  int tests_failed;

  down_count_monitor #(
    .CNT_W    (CNT_W),
    .EXT_W    (EXT_W),
    .STABLE_N (STABLE_N)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cnt_in     (cnt_in),
    .clr        (clr),
    .irq_ack    (irq_ack),
    .cnt_vld    (cnt_vld),
    .cnt_q      (cnt_q),
    .wrap_pulse (wrap_pulse),
    .ext_cnt    (ext_cnt),
    .irq        (irq)
`ifdef DCM_STEP_CHK_EN
    ,
    .err        (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a value is accepted STABLE_N+1 edges after it was first
  // sampled, provided the input was sampled identically STABLE_N times in a row.
  logic [CNT_W-1:0] hist[$];
  logic             m_vld;
  logic [CNT_W-1:0] m_q;
  logic             m_wrap;
  logic [EXT_W-1:0] m_ext;
  logic             m_irq;
`ifdef DCM_STEP_CHK_EN
  logic             m_err;
`endif

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist.delete();
      m_vld  = 1'b0;
      m_q    = '0;
      m_wrap = 1'b0;
      m_ext  = '0;
      m_irq  = 1'b0;
`ifdef DCM_STEP_CHK_EN
      m_err  = 1'b0;
`endif
    end else begin : mdl
      int               sz;
      bit               stable;
      bit               w;
      logic [CNT_W-1:0] cand;
      sz     = hist.size();
      stable = (sz >= STABLE_N + 1);
      cand   = '0;
      if (stable) begin
        cand = hist[sz-2];
        for (int t = sz - 1 - STABLE_N; t < sz - 1; t++)
          if (hist[t] != cand) stable = 0;
      end
      hist.push_back(cnt_in);
      if (hist.size() > 32) void'(hist.pop_front());
      w      = 0;
      m_wrap = 1'b0;
      if (clr) begin
        m_vld = 1'b0;
        m_ext = '0;
        m_irq = 1'b0;
`ifdef DCM_STEP_CHK_EN
        m_err = 1'b0;
`endif
      end else begin
        if (stable) begin
          if (!m_vld) begin
            m_q   = cand;
            m_vld = 1'b1;
          end else if (cand != m_q) begin
            w = (m_q == 0) && (cand == MAXV);
`ifdef DCM_STEP_CHK_EN
            if (!w && (cand != m_q - 1'b1)) m_err = 1'b1;
`endif
            m_q = cand;
          end
        end
        if (irq_ack) m_irq = 1'b0;
        if (w) begin
          m_wrap = 1'b1;
          m_ext  = m_ext + 1'b1;
          m_irq  = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    tests_run++;
    if ({cnt_vld, cnt_q, wrap_pulse, ext_cnt, irq} !== '0) begin
      tests_failed++;
      $display("FAIL reset_init: got %h required 0", {cnt_vld, cnt_q, wrap_pulse, ext_cnt, irq});
    end
    cnt_in = 4'h3;
    rst    = 1'b1;
    repeat (6) step();
    tests_run++;
    if (cnt_q !== 4'h3 || cnt_vld !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_prerun: got vld=%b q=%h required vld=1 q=3", cnt_vld, cnt_q);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if ({cnt_vld, cnt_q, wrap_pulse, ext_cnt, irq} !== '0) begin
      tests_failed++;
      $display("FAIL reset_async: got %h required 0", {cnt_vld, cnt_q, wrap_pulse, ext_cnt, irq});
    end
    @(negedge clk);
    cnt_in = 4'hF;
    rst    = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      tests_run++;
      if ({cnt_vld, cnt_q, wrap_pulse, ext_cnt, irq} !== {m_vld, m_q, m_wrap, m_ext, m_irq}) begin
        tests_failed++;
        $display("FAIL reset_release_c%0d: got %h required %h", i,
                 {cnt_vld, cnt_q, wrap_pulse, ext_cnt, irq}, {m_vld, m_q, m_wrap, m_ext, m_irq});
      end
      if (i == 3) begin
        tests_run++;
        if (cnt_vld !== 1'b0) begin
          tests_failed++;
          $display("FAIL reset_early_vld: got %b required 0", cnt_vld);
        end
      end
    end
    tests_run++;
    if (cnt_vld !== 1'b1 || cnt_q !== 4'hF || wrap_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_first_load: got vld=%b q=%h wrap=%b required vld=1 q=f wrap=0",
               cnt_vld, cnt_q, wrap_pulse);
    end
  endtask

  task automatic test_down_sequence();
    int pulses = 0;
    for (int v = 16; v >= 0; v--) begin
      cnt_in = (v == 16) ? 4'hF : v[3:0];
      if (v == 0) begin
        for (int k = 0; k < 4; k++) begin
          step();
          pulses += int'(wrap_pulse);
        end
        cnt_in = 4'hF;
      end
      for (int k = 0; k < 4; k++) begin
        step();
        pulses += int'(wrap_pulse);
        tests_run++;
        if ({cnt_vld, cnt_q, wrap_pulse, ext_cnt, irq} !== {m_vld, m_q, m_wrap, m_ext, m_irq}) begin
          tests_failed++;
          $display("FAIL down_seq_v%0d: got %h required %h", v,
                   {cnt_vld, cnt_q, wrap_pulse, ext_cnt, irq}, {m_vld, m_q, m_wrap, m_ext, m_irq});
        end
      end
    end
    tests_run++;
    if (pulses != 1 || ext_cnt !== 8'd1 || irq !== 1'b1 || cnt_q !== 4'hF) begin
      tests_failed++;
      $display("FAIL down_seq_wrap: got pulses=%0d ext=%0d irq=%b q=%h required 1 1 1 f",
               pulses, ext_cnt, irq, cnt_q);
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    cnt_in = 4'h5;
    repeat (6) step();
    cnt_in = 4'h7;
    step();
    pulses += int'(wrap_pulse);
    cnt_in = 4'h5;
    for (int k = 0; k < 6; k++) begin
      step();
      pulses += int'(wrap_pulse);
      tests_run++;
      if (cnt_q !== 4'h5 || cnt_q !== m_q) begin
        tests_failed++;
        $display("FAIL glitch_hold_c%0d: got q=%h required 5 (model %h)", k, cnt_q, m_q);
      end
    end
    tests_run++;
    if (pulses != 0) begin
      tests_failed++;
      $display("FAIL glitch_wrap: got %0d pulses required 0", pulses);
    end
  endtask

  task automatic test_irq();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    tests_run++;
    if (irq !== 1'b0 || irq !== m_irq) begin
      tests_failed++;
      $display("FAIL irq_ack_clear: got %b required 0", irq);
    end
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL irq_ack_idle: got %b required 0", irq);
    end
    for (int v = 4; v >= 0; v--) begin
      cnt_in = v[3:0];
      repeat (4) step();
    end
    cnt_in = 4'hF;
    repeat (3) step();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    tests_run++;
    if (wrap_pulse !== 1'b1 || irq !== 1'b1 || ext_cnt !== 8'd2) begin
      tests_failed++;
      $display("FAIL irq_ack_vs_wrap: got wrap=%b irq=%b ext=%0d required 1 1 2",
               wrap_pulse, irq, ext_cnt);
    end
    tests_run++;
    if ({cnt_vld, cnt_q, wrap_pulse, ext_cnt, irq} !== {m_vld, m_q, m_wrap, m_ext, m_irq}) begin
      tests_failed++;
      $display("FAIL irq_model: got %h required %h",
               {cnt_vld, cnt_q, wrap_pulse, ext_cnt, irq}, {m_vld, m_q, m_wrap, m_ext, m_irq});
    end
  endtask

  task automatic test_random();
    logic [CNT_W-1:0] cur = cnt_in;
    for (int n = 0; n < 300; n++) begin
      int hold;
      if ($urandom_range(3, 0) != 0) cur = cur - 1'b1;
      else cur = CNT_W'($urandom_range(15, 0));
      hold   = $urandom_range(5, 1);
      cnt_in = cur;
      for (int k = 0; k < hold; k++) begin
        irq_ack = ($urandom_range(3, 0) == 0);
        clr     = ($urandom_range(19, 0) == 0);
        step();
        irq_ack = 1'b0;
        clr     = 1'b0;
        tests_run++;
        if ({cnt_vld, cnt_q, wrap_pulse, ext_cnt, irq} !== {m_vld, m_q, m_wrap, m_ext, m_irq}) begin
          tests_failed++;
          $display("FAIL random_n%0d: got %h required %h", n,
                   {cnt_vld, cnt_q, wrap_pulse, ext_cnt, irq}, {m_vld, m_q, m_wrap, m_ext, m_irq});
        end
`ifdef DCM_STEP_CHK_EN
        tests_run++;
        if (err !== m_err) begin
          tests_failed++;
          $display("FAIL random_err_n%0d: got %b required %b", n, err, m_err);
        end
`endif
      end
    end
  endtask

  task automatic test_ext_wrap();
    cnt_in = 4'h0;
    clr    = 1'b1;
    step();
    clr    = 1'b0;
    tests_run++;
    if (cnt_vld !== 1'b0 || ext_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL ext_pre_clr: got vld=%b ext=%0d required 0 0", cnt_vld, ext_cnt);
    end
    repeat (4) step();
    for (int i = 0; i < 256; i++) begin
      cnt_in = 4'hF;
      repeat (3) step();
      cnt_in = 4'h0;
      for (int k = 0; k < 3; k++) begin
        step();
        tests_run++;
        if ({wrap_pulse, ext_cnt, irq} !== {m_wrap, m_ext, m_irq}) begin
          tests_failed++;
          $display("FAIL ext_wrap_i%0d: got %h required %h", i,
                   {wrap_pulse, ext_cnt, irq}, {m_wrap, m_ext, m_irq});
        end
      end
      if (i == 254) begin
        tests_run++;
        if (ext_cnt !== 8'd255) begin
          tests_failed++;
          $display("FAIL ext_at_255: got %0d required 255", ext_cnt);
        end
      end
    end
    repeat (3) step();
    tests_run++;
    if (ext_cnt !== 8'd0 || irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL ext_rollover: got ext=%0d irq=%b required 0 1", ext_cnt, irq);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    tests_run++;
    if (cnt_vld !== 1'b0 || irq !== 1'b0 || ext_cnt !== 8'd0 || wrap_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL ext_clr: got vld=%b irq=%b ext=%0d wrap=%b required all 0",
               cnt_vld, irq, ext_cnt, wrap_pulse);
    end
    repeat (2) step();
    tests_run++;
    if (cnt_vld !== 1'b1 || cnt_q !== 4'h0) begin
      tests_failed++;
      $display("FAIL ext_reload: got vld=%b q=%h required 1 0", cnt_vld, cnt_q);
    end
  endtask

`ifdef DCM_STEP_CHK_EN
  task automatic test_step_chk();
    cnt_in = 4'h9;
    repeat (5) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (2) step();
    tests_run++;
    if (err !== 1'b0 || cnt_q !== 4'h9) begin
      tests_failed++;
      $display("FAIL step_load9: got err=%b q=%h required 0 9", err, cnt_q);
    end
    cnt_in = 4'h6;
    repeat (5) step();
    tests_run++;
    if (err !== 1'b1 || cnt_q !== 4'h6) begin
      tests_failed++;
      $display("FAIL step_err: got err=%b q=%h required 1 6", err, cnt_q);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("FAIL step_clr: got err=%b required 0", err);
    end
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b0;
    cnt_in       = '0;
    clr          = 1'b0;
    irq_ack      = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_down_sequence();
    test_glitch();
    test_irq();
    test_random();
    test_ext_wrap();
`ifdef DCM_STEP_CHK_EN
    test_step_chk();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
